// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like memory port between the instruction and data masters.
// Zero-latency forwarding; an in-order ID FIFO routes each data_ok back to its issuer.
module sram_like_arbiter #(
  parameter int DEPTH    = 4,
  parameter int ARB_MODE = 0
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        orphan_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ZERO_C = {(AW+1){1'b0}};
  localparam logic [AW:0] ONE_C  = {{AW{1'b0}}, 1'b1};

  logic [DEPTH-1:0] id_fifo_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             lock_r;
  logic             sel_locked_r;
  logic             rr_last_r;
  logic             orphan_err_r;

  logic sel_s;
  logic sel_req_s;
  logic not_full_s;
  logic accept_s;
  logic pop_s;
  logic head_id_s;

  // Master selection: 1 selects the data master.
  always_comb begin
    sel_s = 1'b0;
    if (lock_r) begin
      sel_s = sel_locked_r;
    end else if (inst_req && data_req) begin
      if (ARB_MODE == 1) begin
        sel_s = 1'b1;
      end else begin
        sel_s = ~rr_last_r;
      end
    end else if (data_req) begin
      sel_s = 1'b1;
    end else begin
      sel_s = 1'b0;
    end
  end

  // Forward the selected master and derive handshake strobes.
  always_comb begin
    sel_req_s  = sel_s ? data_req : inst_req;
    not_full_s = (count_r != FULL_C);
    mem_req    = aresetn & sel_req_s & not_full_s;
    mem_wr     = sel_s ? data_wr    : inst_wr;
    mem_size   = sel_s ? data_size  : inst_size;
    mem_addr   = sel_s ? data_addr  : inst_addr;
    mem_wdata  = sel_s ? data_wdata : inst_wdata;
    accept_s   = mem_req & mem_addr_ok;
    pop_s      = aresetn & mem_data_ok & (count_r != ZERO_C);
    head_id_s  = id_fifo_r[rd_ptr_r];
    inst_addr_ok = accept_s & ~sel_s;
    data_addr_ok = accept_s & sel_s;
    inst_data_ok = pop_s & ~head_id_s;
    data_data_ok = pop_s & head_id_s;
    inst_rdata   = mem_rdata;
    data_rdata   = mem_rdata;
    orphan_err   = orphan_err_r;
  end

  // Grant lock, round-robin history and orphan flag.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lock_r       <= 1'b0;
      sel_locked_r <= 1'b0;
      rr_last_r    <= 1'b0;
      orphan_err_r <= 1'b0;
    end else begin
      if (mem_req && !mem_addr_ok) begin
        lock_r       <= 1'b1;
        sel_locked_r <= sel_s;
      end else if (accept_s) begin
        lock_r       <= 1'b0;
      end
      if (accept_s) begin
        rr_last_r <= sel_s;
      end
      // A completion with nothing outstanding means the slave lost sync with us.
      if (mem_data_ok && (count_r == ZERO_C)) begin
        orphan_err_r <= 1'b1;
      end
    end
  end

  // In-order outstanding-transaction ID FIFO.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      id_fifo_r <= {DEPTH{1'b0}};
      wr_ptr_r  <= {AW{1'b0}};
      rd_ptr_r  <= {AW{1'b0}};
      count_r   <= ZERO_C;
    end else begin
      if (accept_s) begin
        id_fifo_r[wr_ptr_r] <= sel_s;
        wr_ptr_r            <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({accept_s, pop_s})
        2'b10:   count_r <= count_r + ONE_C;
        2'b01:   count_r <= count_r - ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Scoreboard bench for sram_like_arbiter (DEPTH=4, round-robin).
// Stimulus queues expected grants/completions; a monitor checks them at negedge.
module tb_sram_like_arbiter;

  typedef struct packed {
    logic        id;
    logic [31:0] val;
  } exp_t;

  logic        clk;
  logic        aresetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, mem_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok, orphan_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  exp_t gq[$];
  exp_t dq[$];
  int   checks = 0;
  int   errors = 0;

  sram_like_arbiter #(.DEPTH(4), .ARB_MODE(0)) dut (
    .aclk(clk), .aresetn(aresetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .orphan_err(orphan_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_g(input logic id, input logic [31:0] a);
    exp_t e;
    e.id = id; e.val = a;
    gq.push_back(e);
  endtask

  task automatic push_d(input logic id, input logic [31:0] r);
    exp_t e;
    e.id = id; e.val = r;
    dq.push_back(e);
  endtask

  initial begin
    exp_t e;
    aresetn = 1'b0;
    inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'h0; inst_wdata = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0; data_wdata = 32'h0;
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h0;

    fork
      forever begin
        @(negedge clk);
        if (inst_addr_ok || data_addr_ok) begin
          if (inst_addr_ok && data_addr_ok) begin
            chk("grant_both", 32'd1, 32'd0);
          end else if (gq.size() == 0) begin
            chk("grant_unexpected", {31'd0, data_addr_ok}, 32'hFFFFFFFF);
          end else begin
            e = gq.pop_front();
            chk("grant_id", {31'd0, data_addr_ok}, {31'd0, e.id});
            chk("grant_addr", mem_addr, e.val);
          end
        end
        if (inst_data_ok || data_data_ok) begin
          if (inst_data_ok && data_data_ok) begin
            chk("done_both", 32'd1, 32'd0);
          end else if (dq.size() == 0) begin
            chk("done_unexpected", {31'd0, data_data_ok}, 32'hFFFFFFFF);
          end else begin
            e = dq.pop_front();
            chk("done_id", {31'd0, data_data_ok}, {31'd0, e.id});
            chk("done_rdata", data_data_ok ? data_rdata : inst_rdata, e.val);
          end
        end
      end
    join_none

    // reset state with requests and slave strobes active
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_addr_ok", {30'd0, data_addr_ok, inst_addr_ok}, 32'd0);
    chk("rst_data_ok", {30'd0, data_data_ok, inst_data_ok}, 32'd0);
    chk("rst_orphan", {31'd0, orphan_err}, 32'd0);
    step();
    aresetn = 1'b1; inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    step();

    // single inst read
    inst_req = 1'b1; inst_addr = 32'hBFC00000; mem_addr_ok = 1'b1;
    push_g(1'b0, 32'hBFC00000);
    @(negedge clk);
    chk("t1_mem_req", {31'd0, mem_req}, 32'd1);
    step();
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h3C080001;
    push_d(1'b0, 32'h3C080001);
    step();
    mem_data_ok = 1'b0;

    // round-robin, both requesting: data, inst, data, inst
    inst_req = 1'b1; data_req = 1'b1; inst_addr = 32'h00400000; data_addr = 32'h10010000;
    mem_addr_ok = 1'b1;
    push_g(1'b1, 32'h10010000); step();
    push_g(1'b0, 32'h00400000); step();
    push_g(1'b1, 32'h10010000); step();
    push_g(1'b0, 32'h00400000); step();
    inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    mem_rdata = 32'h11110000; push_d(1'b1, 32'h11110000); step();
    mem_rdata = 32'h22220001; push_d(1'b0, 32'h22220001); step();
    mem_rdata = 32'h33330002; push_d(1'b1, 32'h33330002); step();
    mem_rdata = 32'h44440003; push_d(1'b0, 32'h44440003); step();
    mem_data_ok = 1'b0;

    // lock: data granted while slave stalls, inst toggles
    data_req = 1'b1; data_addr = 32'h80001000; inst_addr = 32'h00400100;
    for (int k = 0; k < 3; k++) begin
      inst_req = (k != 1);
      @(negedge clk);
      chk("lock_addr", mem_addr, 32'h80001000);
      step();
    end
    inst_req = 1'b1; mem_addr_ok = 1'b1;
    push_g(1'b1, 32'h80001000); step();
    data_req = 1'b0;
    push_g(1'b0, 32'h00400100); step();
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    mem_rdata = 32'h55550000; push_d(1'b1, 32'h55550000); step();
    mem_rdata = 32'h66660000; push_d(1'b0, 32'h66660000); step();
    mem_data_ok = 1'b0;

    // full: four accepts, fifth blocked until a completion
    inst_req = 1'b1; inst_addr = 32'h00400200; mem_addr_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push_g(1'b0, 32'h00400200);
      step();
    end
    mem_data_ok = 1'b1; mem_rdata = 32'h77770000; push_d(1'b0, 32'h77770000);
    @(negedge clk);
    chk("full_mem_req", {31'd0, mem_req}, 32'd0);
    step();
    mem_data_ok = 1'b0; push_g(1'b0, 32'h00400200);
    @(negedge clk);
    chk("refill_mem_req", {31'd0, mem_req}, 32'd1);
    step();
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    mem_rdata = 32'h77770001; push_d(1'b0, 32'h77770001); step();
    mem_rdata = 32'h77770002; push_d(1'b0, 32'h77770002); step();
    mem_rdata = 32'h77770003; push_d(1'b0, 32'h77770003); step();
    mem_rdata = 32'h77770004; push_d(1'b0, 32'h77770004); step();
    mem_data_ok = 1'b0;

    // orphan completion after reset
    aresetn = 1'b0; step();
    aresetn = 1'b1; step();
    mem_data_ok = 1'b1;
    @(negedge clk);
    chk("orphan_before", {31'd0, orphan_err}, 32'd0);
    step();
    mem_data_ok = 1'b0;
    @(negedge clk);
    chk("orphan_set", {31'd0, orphan_err}, 32'd1);
    step(); step();
    @(negedge clk);
    chk("orphan_sticky", {31'd0, orphan_err}, 32'd1);

    // async reset with two outstanding
    step();
    aresetn = 1'b0; step();
    @(negedge clk);
    chk("rst_clears_orphan", {31'd0, orphan_err}, 32'd0);
    step();
    aresetn = 1'b1; inst_req = 1'b1; inst_addr = 32'h00400300; mem_addr_ok = 1'b1;
    push_g(1'b0, 32'h00400300); step();
    push_g(1'b0, 32'h00400300); step();
    mem_data_ok = 1'b1;
    #2;
    aresetn = 1'b0;
    #1;
    chk("async_mem_req", {31'd0, mem_req}, 32'd0);
    chk("async_addr_ok", {30'd0, data_addr_ok, inst_addr_ok}, 32'd0);
    chk("async_data_ok", {30'd0, data_data_ok, inst_data_ok}, 32'd0);
    step();
    aresetn = 1'b1; inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    step();
    mem_data_ok = 1'b1;
    @(negedge clk);
    chk("post_rst_no_done", {30'd0, data_data_ok, inst_data_ok}, 32'd0);
    step();
    mem_data_ok = 1'b0;
    @(negedge clk);
    chk("post_rst_orphan", {31'd0, orphan_err}, 32'd1);

    step();
    chk("grant_queue_drained", gq.size(), 32'd0);
    chk("done_queue_drained", dq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
